// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Shared definitions for the board refresh controller:
//   - default board geometry (ROWS x COLS)
//   - controller state encoding
//   - line-clear score table, indexed by min(lines, 4)
//   - cell_field(): extracts the 5-bit coordinate of cell 0..3 from a packed
//     20-bit piece coordinate vector (cell i lives at [5i+4:5i])
// -----------------------------------------------------------------------------
package board_pkg;

  localparam int ROWS = 20;
  localparam int COLS = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOCK,
    COMPACT,
    CLEAR,
    DONE
  } state_t;

  // Entry n is the reward for clearing n lines at once; 4 or more use entry 4.
  localparam logic [4:0][15:0] SCORE_TABLE = {16'd8, 16'd5, 16'd3, 16'd1, 16'd0};

  function automatic logic [4:0] cell_field(input logic [19:0] packed_cells,
                                            input logic [1:0]  idx);
    logic [4:0] f;
    case (idx)
      2'd0:    f = packed_cells[4:0];
      2'd1:    f = packed_cells[9:5];
      2'd2:    f = packed_cells[14:10];
      default: f = packed_cells[19:15];
    endcase
    return f;
  endfunction

endpackage

// File: rtl/board_refresh_ctrl_if.sv
// -----------------------------------------------------------------------------
// board_refresh_ctrl_if
// Bundles the player handshake, the board row-RAM port and the status outputs
// of the refresh controller.
//   master : the controller (drives RAM strobes/address/data and status)
//   slave  : the environment (player + RAM; drives refresh, piece, ram_rdata)
// Signals:
//   refresh        start pulse            piece_x/piece_y  4 x 5-bit cells
//   ram_addr       row address            ram_rd_en        read strobe
//   ram_rdata      read row (next cycle)  ram_we/ram_wdata write strobe/row
//   busy           not IDLE               refresh_done     end-of-sequence pulse
//   lines_cleared  rows removed last run  score            accumulated score
// -----------------------------------------------------------------------------
interface board_refresh_ctrl_if #(
  parameter int COLS = 10,
  parameter int AW   = 5
);
  logic            refresh;
  logic [19:0]     piece_x;
  logic [19:0]     piece_y;
  logic [AW-1:0]   ram_addr;
  logic            ram_rd_en;
  logic [COLS-1:0] ram_rdata;
  logic            ram_we;
  logic [COLS-1:0] ram_wdata;
  logic            busy;
  logic            refresh_done;
  logic [4:0]      lines_cleared;
  logic [15:0]     score;

  modport master (
    input  refresh, piece_x, piece_y, ram_rdata,
    output ram_addr, ram_rd_en, ram_we, ram_wdata,
    output busy, refresh_done, lines_cleared, score
  );

  modport slave (
    output refresh, piece_x, piece_y, ram_rdata,
    input  ram_addr, ram_rd_en, ram_we, ram_wdata,
    input  busy, refresh_done, lines_cleared, score
  );
endinterface

// File: rtl/board_score_acc.sv
// -----------------------------------------------------------------------------
// board_score_acc
// Saturating 16-bit score accumulator. On each i_done strobe it adds the table
// reward for i_k cleared lines (capped at the 4-line reward) and clamps at
// 16'hFFFF.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   i_k       lines cleared by the finishing sequence
//   i_done    one-cycle strobe: sequence finishing this cycle
//   o_score   accumulated score
// -----------------------------------------------------------------------------
module board_score_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_k,
  input  logic        i_done,
  output logic [15:0] o_score
);
  import board_pkg::*;

  logic [15:0] r_score;
  logic [2:0]  w_idx;
  logic [16:0] w_sum;

  assign w_idx = (i_k > 5'd4) ? 3'd4 : i_k[2:0];
  assign w_sum = {1'b0, r_score} + {1'b0, SCORE_TABLE[w_idx]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score <= '0;
    end else if (i_done) begin
      r_score <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

  assign o_score = r_score;
endmodule

// File: rtl/board_refresh_ctrl.sv
// -----------------------------------------------------------------------------
// board_refresh_ctrl
// Post-landing board sequencer: LOCK writes the 4 piece cells into the row RAM
// by read-modify-write, COMPACT removes full rows bottom-up by copying the
// surviving rows down, CLEAR zero-fills the k vacated top rows, DONE publishes
// lines_cleared/score and returns to IDLE. Owns the RAM port while busy.
// Optional feature macro: BOARD_SCORE_EN (score accumulation; when undefined
// score is tied to 0 and no scoring logic is built).
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       board_refresh_ctrl_if.master (handshake, RAM port, status)
// Timing: refresh_done, lines_cleared and score are registered at the end of
// the DONE cycle, so they appear in the cycle after DONE.
// -----------------------------------------------------------------------------
module board_refresh_ctrl #(
  parameter int ROWS = board_pkg::ROWS,
  parameter int COLS = board_pkg::COLS,
  parameter int AW   = 5
) (
  input logic                  clk,
  input logic                  rst,
  board_refresh_ctrl_if.master bus
);
  import board_pkg::*;

  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [4:0]    ROWS_5   = 5'(ROWS);
  localparam logic [4:0]    COLS_5   = 5'(COLS);

  state_t          r_state;
  state_t          w_state_next;
  logic [19:0]     r_px;
  logic [19:0]     r_py;
  logic [1:0]      r_cell;
  logic            r_phase;     // 0: read cycle, 1: write/decide cycle
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [4:0]      r_k;
  logic [4:0]      r_clr;       // rows still to zero-fill in CLEAR
  logic            r_done;
  logic [4:0]      r_lines;

  logic [4:0]      w_cell_x;
  logic [4:0]      w_cell_y;
  logic            w_cell_valid;
  logic [COLS-1:0] w_cell_bit;
  logic            w_row_full;
  logic [4:0]      w_k_next;

  assign w_cell_x     = cell_field(r_px, r_cell);
  assign w_cell_y     = cell_field(r_py, r_cell);
  // Off-board cells are skipped entirely: no read, no write.
  assign w_cell_valid = (w_cell_y < ROWS_5) && (w_cell_x < COLS_5);
  assign w_cell_bit   = {{(COLS-1){1'b0}}, 1'b1} << w_cell_x;
  assign w_row_full   = &bus.ram_rdata;
  assign w_k_next     = w_row_full ? (r_k + 5'd1) : r_k;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and RAM port; strobes are decoded from the current state so an
  // asynchronous reset drops them immediately.
  always_comb begin
    w_state_next  = r_state;
    bus.ram_addr  = '0;
    bus.ram_rd_en = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    case (r_state)
      IDLE: begin
        if (bus.refresh) w_state_next = LOCK;
      end
      LOCK: begin
        bus.ram_addr = w_cell_valid ? AW'(w_cell_y) : '0;
        if (!r_phase) begin
          bus.ram_rd_en = w_cell_valid;
        end else begin
          bus.ram_we    = w_cell_valid;
          bus.ram_wdata = bus.ram_rdata | w_cell_bit;
          if (r_cell == 2'd3) w_state_next = COMPACT;
        end
      end
      COMPACT: begin
        if (!r_phase) begin
          bus.ram_addr  = r_rd;
          bus.ram_rd_en = 1'b1;
        end else begin
          bus.ram_addr = r_wr;
          // Survivor rows move down only once a full row has been skipped.
          if (!w_row_full && (r_wr != r_rd)) begin
            bus.ram_we    = 1'b1;
            bus.ram_wdata = bus.ram_rdata;
          end
          if (r_rd == '0) w_state_next = (w_k_next != 5'd0) ? CLEAR : DONE;
        end
      end
      CLEAR: begin
        bus.ram_addr = r_wr;
        bus.ram_we   = 1'b1;
        if (r_clr == 5'd1) w_state_next = DONE;
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_px    <= '0;
      r_py    <= '0;
      r_cell  <= '0;
      r_phase <= 1'b0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_k     <= '0;
      r_clr   <= '0;
      r_done  <= 1'b0;
      r_lines <= '0;
    end else begin
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (bus.refresh) begin
            r_px    <= bus.piece_x;
            r_py    <= bus.piece_y;
            r_cell  <= '0;
            r_phase <= 1'b0;
          end
        end
        LOCK: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            r_cell <= r_cell + 2'd1;
            if (r_cell == 2'd3) begin
              r_rd <= LAST_ROW;
              r_wr <= LAST_ROW;
              r_k  <= '0;
            end
          end
        end
        COMPACT: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            r_k   <= w_k_next;
            r_clr <= w_k_next;
            r_rd  <= r_rd - ADDR_ONE;
            if (!w_row_full) r_wr <= r_wr - ADDR_ONE;
          end
        end
        CLEAR: begin
          r_wr  <= r_wr - ADDR_ONE;
          r_clr <= r_clr - 5'd1;
        end
        DONE: begin
          r_lines <= r_k;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy          = (r_state != IDLE);
  assign bus.refresh_done  = r_done;
  assign bus.lines_cleared = r_lines;

`ifdef BOARD_SCORE_EN
  board_score_acc u_score (
    .clk     (clk),
    .rst     (rst),
    .i_k     (r_k),
    .i_done  (r_state == DONE),
    .o_score (bus.score)
  );
`else
  assign bus.score = '0;
`endif

endmodule

// File: tb/tb_board_refresh_ctrl.sv
// -----------------------------------------------------------------------------
// tb_board_refresh_ctrl
// Self-checking bench: a behavioural RAM with registered read, a reference
// model that applies the landing rules directly to a board array (set piece
// bits, drop full rows, pad zeros on top), directed scenarios and randomized
// boards/pieces.
// Cycle numbering: refresh is sampled at edge N; the clock period that ends at
// edge N+j is cycle N+j. refresh_done is expected in cycle N+10+2*ROWS+k.
// -----------------------------------------------------------------------------
module tb_board_refresh_ctrl;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  board_refresh_ctrl_if #(.COLS(COLS), .AW(AW)) bus ();

  board_refresh_ctrl #(.ROWS(ROWS), .COLS(COLS), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  // Board RAM with registered read and a bench-side load port.
  logic [COLS-1:0] ram [ROWS];
  logic            load_en = 1'b0;
  logic [4:0]      load_addr = '0;
  logic [COLS-1:0] load_data = '0;

  always @(posedge clk) begin
    if (load_en) begin
      ram[load_addr] <= load_data;
    end else begin
      if (bus.ram_we && int'(bus.ram_addr) < ROWS) ram[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_rd_en && int'(bus.ram_addr) < ROWS) bus.ram_rdata <= ram[bus.ram_addr];
    end
  end

  // Port-protocol monitor: strobes exclusive, address on-board.
  always @(negedge clk) begin
    if (!rst) begin
      if ((bus.ram_rd_en && bus.ram_we) ||
          ((bus.ram_rd_en || bus.ram_we) && int'(bus.ram_addr) >= ROWS))
        viol <= viol + 1;
    end
  end

  // Reference model state
  logic [COLS-1:0] init_b [ROWS];
  logic [COLS-1:0] exp_b  [ROWS];
  int              exp_k;
  int              exp_score = 0;
  logic [4:0]      cx [4];
  logic [4:0]      cy [4];

  function automatic int points(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      2:       return 3;
      3:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic logic cell_ok(input int i);
    return (int'(cy[i]) < ROWS) && (int'(cx[i]) < COLS);
  endfunction

  task automatic model_run();
    logic [COLS-1:0] b [ROWS];
    logic [COLS-1:0] kept [$];
    for (int y = 0; y < ROWS; y++) b[y] = init_b[y];
    for (int i = 0; i < 4; i++)
      if (cell_ok(i)) b[cy[i]][cx[i]] = 1'b1;
    for (int y = ROWS - 1; y >= 0; y--)
      if (b[y] != {COLS{1'b1}}) kept.push_back(b[y]);
    exp_k = ROWS - kept.size();
    for (int j = 0; j < ROWS; j++)
      exp_b[ROWS-1-j] = (j < kept.size()) ? kept[j] : '0;
`ifdef BOARD_SCORE_EN
    exp_score = exp_score + points(exp_k);
    if (exp_score > 65535) exp_score = 65535;
`endif
  endtask

  task automatic load_board();
    for (int y = 0; y < ROWS; y++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_addr = 5'(y);
      load_data = init_b[y];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic set_piece(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int x3, input int y3);
    cx[0] = 5'(x0); cy[0] = 5'(y0);
    cx[1] = 5'(x1); cy[1] = 5'(y1);
    cx[2] = 5'(x2); cy[2] = 5'(y2);
    cx[3] = 5'(x3); cy[3] = 5'(y3);
  endtask

  task automatic clear_init();
    for (int y = 0; y < ROWS; y++) init_b[y] = '0;
  endtask

  // Runs one refresh sequence from init_b/cx/cy and checks everything.
  // dup_at > 0 injects a second refresh pulse (with a different piece) in that
  // cycle, which must be ignored.
  task automatic run_refresh(input string name, input int dup_at);
    int          cyc;
    int          extra;
    int          bad_row;
    logic [31:0] got_strb;
    logic [31:0] exp_strb;
    model_run();
    load_board();
    for (int i = 0; i < 4; i++) begin
      bus.piece_x[5*i +: 5] = cx[i];
      bus.piece_y[5*i +: 5] = cy[i];
    end
    @(negedge clk);
    bus.refresh = 1'b1;
    @(posedge clk);            // edge N
    @(negedge clk);
    bus.refresh = 1'b0;
    cyc = 1;
    got_strb = '0;
    while (cyc < 300) begin
      if (cyc <= 8) begin
        got_strb[2*(cyc-1)]   = bus.ram_rd_en;
        got_strb[2*(cyc-1)+1] = bus.ram_we;
      end
      if (bus.refresh_done) break;
      if (cyc == dup_at) begin
        bus.refresh = 1'b1;
        bus.piece_x = {5'd1, 5'd2, 5'd3, 5'd4};
        bus.piece_y = {5'd0, 5'd0, 5'd0, 5'd0};
      end
      @(posedge clk);
      @(negedge clk);
      bus.refresh = 1'b0;
      cyc++;
    end

    n_checks++;
    if (cyc != 10 + 2*ROWS + exp_k) begin
      n_fail++;
      $display("FAIL %s latency: got cycle N+%0d, expected N+%0d", name, cyc, 10 + 2*ROWS + exp_k);
    end

    exp_strb = '0;
    for (int i = 0; i < 4; i++) begin
      exp_strb[4*i]   = cell_ok(i);   // read in first LOCK cycle of cell i
      exp_strb[4*i+3] = cell_ok(i);   // write in second LOCK cycle of cell i
    end
    n_checks++;
    if (got_strb !== exp_strb) begin
      n_fail++;
      $display("FAIL %s lock_strobes: got %h, expected %h", name, got_strb, exp_strb);
    end

    n_checks++;
    if (bus.lines_cleared !== 5'(exp_k)) begin
      n_fail++;
      $display("FAIL %s lines_cleared: got %0d, expected %0d", name, bus.lines_cleared, exp_k);
    end

    n_checks++;
    if (bus.score !== 16'(exp_score)) begin
      n_fail++;
      $display("FAIL %s score: got %0d, expected %0d", name, bus.score, exp_score);
    end

    bad_row = -1;
    for (int y = ROWS - 1; y >= 0; y--)
      if (ram[y] !== exp_b[y]) bad_row = y;
    n_checks++;
    if (bad_row >= 0) begin
      n_fail++;
      $display("FAIL %s board row %0d: got %h, expected %h", name, bad_row, ram[bad_row], exp_b[bad_row]);
    end

    n_checks++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL %s ram_protocol: got %0d violations, expected 0", name, viol);
    end

    @(negedge clk);
    n_checks++;
    if (bus.refresh_done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse: got done=%b busy=%b, expected 0 0", name, bus.refresh_done, bus.busy);
    end

    if (dup_at > 0) begin
      extra = 0;
      repeat (80) begin
        @(negedge clk);
        if (bus.refresh_done) extra++;
      end
      n_checks++;
      if (extra != 0) begin
        n_fail++;
        $display("FAIL %s extra_done: got %0d extra pulses, expected 0", name, extra);
      end
    end
    $display("[%s] k=%0d done_cycle=N+%0d lines=%0d score=%0d", name, exp_k, cyc,
             bus.lines_cleared, bus.score);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.refresh_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: got busy=%b done=%b, expected 0 0", bus.busy, bus.refresh_done);
    end
    n_checks++;
    if (bus.ram_rd_en !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_addr !== '0 || bus.ram_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_ram_port: got rd=%b we=%b addr=%0d wdata=%h, expected all 0",
               bus.ram_rd_en, bus.ram_we, bus.ram_addr, bus.ram_wdata);
    end
    n_checks++;
    if (bus.lines_cleared !== 5'd0 || bus.score !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counts: got lines=%0d score=%0d, expected 0 0", bus.lines_cleared, bus.score);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b, expected 0", bus.busy);
    end
    $display("[reset] busy=%b lines=%0d score=%0d", bus.busy, bus.lines_cleared, bus.score);
  endtask

  task automatic test_lock_empty();
    clear_init();
    set_piece(3, 18, 4, 18, 3, 19, 4, 19);
    run_refresh("lock_empty", 0);
    n_checks++;
    if (ram[18] !== 10'h018 || ram[19] !== 10'h018) begin
      n_fail++;
      $display("FAIL lock_empty rows18_19: got %h %h, expected 018 018", ram[18], ram[19]);
    end
  endtask

  task automatic test_single_line();
    clear_init();
    init_b[19] = 10'h3E7;
    set_piece(3, 19, 4, 19, 3, 18, 4, 18);
    run_refresh("single_line", 0);
    n_checks++;
    if (ram[19] !== 10'h018 || ram[0] !== 10'h000 || bus.lines_cleared !== 5'd1) begin
      n_fail++;
      $display("FAIL single_line result: got row19=%h row0=%h lines=%0d, expected 018 000 1",
               ram[19], ram[0], bus.lines_cleared);
    end
  endtask

  task automatic test_tetris();
    clear_init();
    for (int y = 16; y < 20; y++) init_b[y] = 10'h3FE;
    set_piece(0, 16, 0, 17, 0, 18, 0, 19);
    run_refresh("tetris", 0);
  endtask

  task automatic test_pattern_compact();
    clear_init();
    init_b[8]  = 10'h0AA;
    init_b[9]  = 10'h155;
    init_b[10] = 10'h0F0;
    init_b[11] = 10'h3FF;
    init_b[12] = 10'h00F;
    init_b[13] = 10'h3FF;
    set_piece(0, 31, 0, 31, 0, 31, 0, 31);
    run_refresh("pattern_compact", 0);
    n_checks++;
    if (ram[13] !== 10'h00F || ram[12] !== 10'h0F0 || ram[11] !== 10'h155 ||
        ram[10] !== 10'h0AA || ram[1] !== 10'h000 || ram[0] !== 10'h000) begin
      n_fail++;
      $display("FAIL pattern_compact rows: got r13=%h r12=%h r11=%h r10=%h r1=%h r0=%h, expected 00F 0F0 155 0AA 000 000",
               ram[13], ram[12], ram[11], ram[10], ram[1], ram[0]);
    end
  endtask

  task automatic test_out_of_range();
    clear_init();
    init_b[5] = 10'h201;
    set_piece(5, 5, 1, 25, 6, 5, 9, 0);
    run_refresh("out_of_range", 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      for (int y = 0; y < ROWS; y++)
        init_b[y] = ($urandom_range(0, 3) == 0) ? {COLS{1'b1}} : 10'($urandom);
      for (int i = 0; i < 4; i++) begin
        cx[i] = 5'($urandom_range(0, 11));
        cy[i] = 5'($urandom_range(0, 21));
      end
      run_refresh($sformatf("random_%0d", t), 0);
    end
  endtask

  task automatic test_reset_midseq();
    int cyc;
    logic found;
    clear_init();
    for (int y = 0; y < ROWS - 1; y++) init_b[y] = 10'($urandom) & 10'h3FE;
    init_b[ROWS-1] = {COLS{1'b1}};
    load_board();
    bus.piece_x = '0;
    bus.piece_y = {4{5'd31}};
    @(negedge clk);
    bus.refresh = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.refresh = 1'b0;
    cyc = 1;
    found = 1'b0;
    while (cyc < 60 && !found) begin
      if (cyc > 8 && bus.ram_we) found = 1'b1;
      else begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL midseq wait_compact_write: got no write within %0d cycles, expected one", cyc);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.ram_we !== 1'b0 || bus.refresh_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midseq async_reset: got busy=%b we=%b done=%b, expected 0 0 0",
               bus.busy, bus.ram_we, bus.refresh_done);
    end
    exp_score = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (bus.lines_cleared !== 5'd0 || bus.score !== 16'd0) begin
      n_fail++;
      $display("FAIL midseq counts_cleared: got lines=%0d score=%0d, expected 0 0",
               bus.lines_cleared, bus.score);
    end
    $display("[midseq_reset] aborted at cycle N+%0d busy=%b", cyc, bus.busy);
    // Continue from whatever the aborted run left in the RAM.
    for (int y = 0; y < ROWS; y++) init_b[y] = ram[y];
    set_piece(2, 10, 3, 10, 4, 10, 5, 10);
    run_refresh("after_abort_dup_refresh", 20);
  endtask

  initial begin
    bus.refresh   = 1'b0;
    bus.piece_x   = '0;
    bus.piece_y   = '0;
    test_reset();
    test_lock_empty();
    test_single_line();
    test_tetris();
    test_pattern_compact();
    test_out_of_range();
    test_random();
    test_reset_midseq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/board_refresh_ctrl.md
Name: board_refresh_ctrl

Overview:
- Sequences the board row-RAM after the falling piece lands. The player's `refresh` pulse starts it, and it returns `refresh_done`.
- Four phases:
  - LOCK: writes the landed piece's 4 cells into the board.
  - COMPACT: scans rows bottom-up and removes full rows by copying the rows above them down.
  - CLEAR: zero-fills the vacated top rows.
  - DONE: pulses `refresh_done` and publishes the line count and score.
- Sole owner of the board RAM port while `busy`.

Parameters:
- ROWS, 20, board height (y range 0..ROWS-1, y=0 is the top row)
- COLS, 10, board width (bit x of a row word is column x)
- AW, 5, RAM address width, ≥ clog2(ROWS)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- refresh  in  1  start pulse from player; honoured only in IDLE
- piece_x  in  20  4 cells × 5-bit x, cell i at [5i+4:5i]
- piece_y  in  20  4 cells × 5-bit y, same packing
- ram_addr  out  AW  row address
- ram_rd_en  out  1  read strobe; `ram_rdata` is valid the following cycle
- ram_rdata  in  COLS  read row
- ram_we  out  1  write strobe
- ram_wdata  out  COLS  write row
- busy  out  1  high in every state except IDLE
- refresh_done  out  1  one-cycle pulse at end of sequence
- lines_cleared  out  5  full rows removed by the last sequence
- score  out  16  accumulated score

Behaviour:
- Reset values: all outputs 0, state IDLE, internal pointers 0.
- Reset asserted mid-sequence aborts immediately: `ram_we` drops the same cycle and no partial-write repair is done.
- IDLE: on `refresh`=1, latch `piece_x`/`piece_y` and move to LOCK. `refresh` outside IDLE is ignored with no queueing.
- LOCK: for cells i=0..3, two cycles each (8 cycles total).
  - Cycle a: `ram_addr`=y_i, `ram_rd_en`=1.
  - Cycle b: `ram_we`=1, `ram_wdata`=`ram_rdata` | (1<<x_i).
  - A cell with y_i≥ROWS or x_i≥COLS spends both cycles idle with no read and no write.
  - Cells sharing a row are correct because each RMW completes before the next read.
- COMPACT: rd and wr both start at ROWS-1; k=0. Per rd, two cycles (2·ROWS cycles total).
  - Cycle a: read row rd.
  - Cycle b, if row full (all COLS bits set): k++; wr unchanged; no write.
  - Cycle b, otherwise: if wr≠rd, write `ram_rdata` to wr. Then decrement wr.
  - Decrement rd after each row; exit when the row rd=0 completes.
  - Writes always go to rows ≥ rd, so no unread data is overwritten.
- CLEAR: write 0 to rows wr, wr-1, …, down to wr-k+1 (exactly k rows, one per cycle). Skipped when k=0.
- DONE: one cycle. `refresh_done`=1, `lines_cleared`<=k, `score` updated, then IDLE.
- Latency: if `refresh` is sampled at edge N, `refresh_done` is high in cycle N+10+2·ROWS+k. For ROWS=20, k=0 that is cycle N+50.
- `ram_rd_en` and `ram_we` are never high in the same cycle. `ram_addr` is always < ROWS when either strobe is high.
- `lines_cleared` holds its value until the next DONE.

Optional Feature:
- Macro: BOARD_SCORE_EN.
- Defined: at DONE, score += table[min(k,4)] with table {0,1,3,5,8}. Saturates at 16'hFFFF.
- Undefined: `score` is tied to 0 and no table logic is built. `lines_cleared` still works.

Decomposition:
- Package board_pkg holds:
  - ROWS, COLS
  - state enum {IDLE, LOCK, COMPACT, CLEAR, DONE}
  - score table constant
  - cell-extract helper function (index → 5-bit x/y)
- One natural sub-module: board_score_acc. Inputs k and the DONE strobe; output the saturating 16-bit `score`. Instantiated only under BOARD_SCORE_EN.

Test Plan:
- Empty board; refresh with cells (3,18),(4,18),(3,19),(4,19) → rows 18/19 read 0x018; lines_cleared=0; refresh_done at N+50; score unchanged.
- Row 19 preloaded 0x3E7; piece fills (3,19),(4,19),(3,18),(4,18) → row 19 full and cleared. Final row 19=0x018, row 0=0; lines_cleared=1; score +1 (BOARD_SCORE_EN); refresh_done at N+51.
- Rows 16..19 preloaded full except column 0; I-piece vertical at x=0, y=16..19 → lines_cleared=4; all rows 0; score +8.
- Pattern in rows 10,12; full rows 11,13 → rows 12,13 end with the old rows 10,12; rows 10,11 end with the old rows 8,9; rows 0,1 end zero; k=2.
- One cell with y=25, others valid → out-of-range cell produces no strobes in its two LOCK cycles; the other three lock correctly.
- Assert rst mid-COMPACT → same cycle: busy=0, ram_we=0, refresh_done=0. A subsequent refresh runs a full sequence. A second refresh pulse while busy is ignored, giving exactly one refresh_done.
